// File: rtl/boot_init_ctrl.sv
// -----------------------------------------------------------------------------
// boot_init_ctrl
//
// Boot/initialisation controller for the MIPS-32 CPU. After reset release (or a
// start request once the CPU is running) it:
//   1. clears the register file, one register per cycle (indices 0..NUM_REGS-1),
//   2. fills instruction memory with an alternating two-word pattern
//      (even addresses get i_pattern_a, odd addresses get i_pattern_b),
//   3. optionally reads the memory back and compares it (BOOT_VERIFY_EN),
//   4. holds the CPU in reset for HOLD_CYCLES cycles, then releases it.
//
// Configuration macro:
//   BOOT_VERIFY_EN  defined   -> VERIFY state compiled in; a read-back mismatch
//                                parks the block in ERROR with o_boot_error = 1.
//                   undefined -> FILL_IM goes straight to HOLD; o_boot_error
//                                is tied 0 and i_im_rdata is ignored.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset_n      asynchronous active-low reset; aborts any sequence at once
//   i_start        re-run the full sequence; honoured only in RUN or ERROR
//   i_pattern_a    fill word for even addresses (sampled live every cycle)
//   i_pattern_b    fill word for odd addresses (sampled live every cycle)
//   o_rf_we        register-file write enable
//   o_rf_waddr     register-file write index
//   o_rf_wdata     register-file write data (always zero)
//   o_im_we        instruction-memory write enable
//   o_im_addr      instruction-memory word address (fill and read-back)
//   o_im_wdata     instruction-memory fill word
//   i_im_rdata     instruction-memory read data, one cycle after o_im_addr
//   o_cpu_reset_n  CPU reset, active-low; high only in RUN
//   o_busy         sequence in progress (CLR_RF, FILL_IM, VERIFY, HOLD)
//   o_done         CPU released (RUN)
//   o_boot_error   sticky read-back mismatch flag (cleared by a new start)
//
// All outputs are registered and change only on the rising clock edge (apart
// from the asynchronous clear). Edge 1 after reset release enters CLR_RF.
// -----------------------------------------------------------------------------
module boot_init_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_AW      = 6,
  parameter int unsigned NUM_REGS    = 34,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_pattern_a,
  input  logic [DATA_WIDTH-1:0] i_pattern_b,
  output logic                  o_rf_we,
  output logic [REG_AW-1:0]     o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_im_we,
  output logic [ADDR_WIDTH-1:0] o_im_addr,
  output logic [DATA_WIDTH-1:0] o_im_wdata,
  input  logic [DATA_WIDTH-1:0] i_im_rdata,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_boot_error
);

  // ---------------------------------------------------------------------------
  // Counter sizing
  // ---------------------------------------------------------------------------
  // The register index and memory address live in the output registers
  // themselves; r_cnt only counts HOLD cycles and, with read-back enabled,
  // VERIFY cycles (which run one past the last address to drain the read).
`ifdef BOOT_VERIFY_EN
  localparam int unsigned CNT_MAX = (MEM_WORDS > HOLD_CYCLES) ? MEM_WORDS : HOLD_CYCLES;
`else
  localparam int unsigned CNT_MAX = HOLD_CYCLES;
`endif
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [REG_AW-1:0]     RF_LAST   = REG_AW'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] IM_LAST   = ADDR_WIDTH'(MEM_WORDS - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BOOT_VERIFY_EN
  // Sweep issues addresses on counts 0..MEM_WORDS-1; the data for the last
  // address arrives on count MEM_WORDS, which is also the exit edge.
  localparam logic [CNT_W-1:0]      VFY_LAST  = CNT_W'(MEM_WORDS);
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StRst,
    StClrRf,
    StFillIm,
    StVerify,
    StHold,
    StRun,
    StError
  } state_e;

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rf_we;
  logic [REG_AW-1:0]     r_rf_waddr;
  logic                  r_im_we;
  logic [ADDR_WIDTH-1:0] r_im_addr;
  logic [DATA_WIDTH-1:0] r_im_wdata;
  logic                  r_cpu_reset_n;
  logic                  r_busy;
  logic                  r_done;

  // ---------------------------------------------------------------------------
  // Next-value helpers
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0]     w_rf_waddr_inc;
  logic [ADDR_WIDTH-1:0] w_im_addr_inc;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_fill_word;

  assign w_rf_waddr_inc = r_rf_waddr + REG_AW'(1);
  assign w_im_addr_inc  = r_im_addr + ADDR_WIDTH'(1);
  assign w_cnt_inc      = r_cnt + CNT_W'(1);

  // Word that goes with the next fill address, from the live pattern inputs.
  assign w_fill_word = w_im_addr_inc[0] ? i_pattern_b : i_pattern_a;

`ifdef BOOT_VERIFY_EN
  logic r_boot_error;
  logic r_vfail;
  logic w_vfy_mis;
  logic w_vfy_fail;

  // On count c the read data belongs to address c-1, so an odd count carries
  // an even address (pattern A). Count 0 has no data yet.
  assign w_vfy_mis  = (r_cnt != '0) &&
                      (i_im_rdata != (r_cnt[0] ? i_pattern_a : i_pattern_b));
  assign w_vfy_fail = r_vfail | w_vfy_mis;
`endif

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StRst;
      r_cnt         <= '0;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_im_we       <= 1'b0;
      r_im_addr     <= '0;
      r_im_wdata    <= '0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef BOOT_VERIFY_EN
      r_boot_error  <= 1'b0;
      r_vfail       <= 1'b0;
`endif
    end else begin
      case (r_state)
        StRst: begin
          // First edge out of reset issues the write to register 0.
          r_state    <= StClrRf;
          r_rf_we    <= 1'b1;
          r_rf_waddr <= '0;
          r_busy     <= 1'b1;
        end

        StClrRf: begin
          if (r_rf_waddr == RF_LAST) begin
            r_state    <= StFillIm;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_im_we    <= 1'b1;
            r_im_addr  <= '0;
            r_im_wdata <= i_pattern_a;
          end else begin
            r_rf_waddr <= w_rf_waddr_inc;
          end
        end

        StFillIm: begin
          if (r_im_addr == IM_LAST) begin
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_cnt      <= '0;
`ifdef BOOT_VERIFY_EN
            r_state    <= StVerify;
            r_vfail    <= 1'b0;
`else
            r_state    <= StHold;
`endif
          end else begin
            r_im_addr  <= w_im_addr_inc;
            r_im_wdata <= w_fill_word;
          end
        end

`ifdef BOOT_VERIFY_EN
        StVerify: begin
          r_cnt <= w_cnt_inc;
          // Park on the last address during the drain cycle.
          if (r_im_addr != IM_LAST) begin
            r_im_addr <= w_im_addr_inc;
          end
          if (r_cnt == VFY_LAST) begin
            r_im_addr <= '0;
            r_cnt     <= '0;
            if (w_vfy_fail) begin
              r_state      <= StError;
              r_boot_error <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state      <= StHold;
            end
          end else begin
            r_vfail <= w_vfy_fail;
          end
        end
`endif

        StHold: begin
          if (r_cnt == HOLD_LAST) begin
            r_state       <= StRun;
            r_cnt         <= '0;
            r_cpu_reset_n <= 1'b1;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StRun, StError: begin
          // Restart drops the CPU reset on the same edge that starts clearing.
          if (i_start) begin
            r_state       <= StClrRf;
            r_rf_we       <= 1'b1;
            r_rf_waddr    <= '0;
            r_busy        <= 1'b1;
            r_cpu_reset_n <= 1'b0;
            r_done        <= 1'b0;
`ifdef BOOT_VERIFY_EN
            r_boot_error  <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= StRst;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_rf_we       = r_rf_we;
  assign o_rf_waddr    = r_rf_waddr;
  assign o_rf_wdata    = '0;
  assign o_im_we       = r_im_we;
  assign o_im_addr     = r_im_addr;
  assign o_im_wdata    = r_im_wdata;
  assign o_cpu_reset_n = r_cpu_reset_n;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

`ifdef BOOT_VERIFY_EN
  assign o_boot_error  = r_boot_error;
`else
  assign o_boot_error  = 1'b0;

  // Read-back data has no consumer without the verify pass.
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_im_rdata;
`endif

endmodule

// File: tb/tb_boot_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_init_ctrl
//
// Scoreboard bench for boot_init_ctrl. Each scenario pushes the per-cycle
// expected output record for the whole sequence when it drives the trigger
// (reset release or start), then pops and compares one record per clock.
// A second instance with default parameters checks the full-size timing.
// -----------------------------------------------------------------------------
module tb_boot_init_ctrl;

  localparam int N = 4;
  localparam int M = 8;
  localparam int H = 2;
`ifdef BOOT_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  // Record index of the first RUN cycle, counted from the trigger edge as 1.
  localparam int LEN      = N + M + H + 1 + (VFY ? M + 1 : 0);
  localparam int DEF_RISE = 34 + 4096 + 4 + 1 + (VFY ? 4097 : 0);

  typedef struct packed {
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        im_we;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        busy;
    logic        berr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pat_a;
  logic [31:0] pat_b;
  logic        corrupt;

  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        im_we;
  logic [11:0] im_addr;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        boot_error;

  logic        rst2_n;
  logic        d_rf_we;
  logic [5:0]  d_rf_waddr;
  logic [31:0] d_rf_wdata;
  logic        d_im_we;
  logic [11:0] d_im_addr;
  logic [31:0] d_im_wdata;
  logic [31:0] d_im_rdata;
  logic        d_cpu_reset_n;
  logic        d_busy;
  logic        d_done;
  logic        d_boot_error;

  int n_cmp = 0;
  int n_err = 0;
  obs_t q_exp[$];

  always #5 clk = ~clk;

  boot_init_ctrl #(
    .DATA_WIDTH (32),
    .REG_AW     (6),
    .NUM_REGS   (N),
    .ADDR_WIDTH (12),
    .MEM_WORDS  (M),
    .HOLD_CYCLES(H)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_pattern_a  (pat_a),
    .i_pattern_b  (pat_b),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_im_we      (im_we),
    .o_im_addr    (im_addr),
    .o_im_wdata   (im_wdata),
    .i_im_rdata   (im_rdata),
    .o_cpu_reset_n(cpu_reset_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_boot_error (boot_error)
  );

  boot_init_ctrl dut_def (
    .i_clock      (clk),
    .i_reset_n    (rst2_n),
    .i_start      (1'b0),
    .i_pattern_a  (32'h012A4020),
    .i_pattern_b  (32'h012A4023),
    .o_rf_we      (d_rf_we),
    .o_rf_waddr   (d_rf_waddr),
    .o_rf_wdata   (d_rf_wdata),
    .o_im_we      (d_im_we),
    .o_im_addr    (d_im_addr),
    .o_im_wdata   (d_im_wdata),
    .i_im_rdata   (d_im_rdata),
    .o_cpu_reset_n(d_cpu_reset_n),
    .o_busy       (d_busy),
    .o_done       (d_done),
    .o_boot_error (d_boot_error)
  );

  // Synchronous memory models: read data valid the cycle after the address.
  logic [31:0] mem  [256];
  logic [31:0] mem2 [4096];

  always @(posedge clk) begin
    if (im_we) mem[im_addr[7:0]] <= im_wdata;
    im_rdata <= mem[im_addr[7:0]] ^
                ((corrupt && im_addr == 12'd5) ? 32'h0000_0100 : 32'h0);
  end

  always @(posedge clk) begin
    if (d_im_we) mem2[d_im_addr] <= d_im_wdata;
    d_im_rdata <= mem2[d_im_addr];
  end

  // Expected outputs k cycles after the trigger edge (k = 1 is that edge).
  function automatic obs_t exp_rec(int k, logic [31:0] pa, logic [31:0] pb, bit err);
    obs_t e = '0;
    int fill_end = N + M;
    int vfy_end  = fill_end + (VFY ? M + 1 : 0);
    if (k <= N) begin
      e.rf_we    = 1'b1;
      e.rf_waddr = 6'(k - 1);
      e.busy     = 1'b1;
    end else if (k <= fill_end) begin
      e.im_we    = 1'b1;
      e.im_addr  = 12'(k - N - 1);
      e.im_wdata = e.im_addr[0] ? pb : pa;
      e.busy     = 1'b1;
    end else if (k <= vfy_end) begin
      e.busy = 1'b1;
    end else if (err) begin
      e.berr = 1'b1;
    end else if (k <= vfy_end + H) begin
      e.busy = 1'b1;
    end else begin
      e.cpu_rst_n = 1'b1;
      e.done      = 1'b1;
    end
    return e;
  endfunction

  function automatic void push_seq(int n, logic [31:0] pa, logic [31:0] pb, bit err);
    for (int k = 1; k <= n; k++) q_exp.push_back(exp_rec(k, pa, pb, err));
  endfunction

  function automatic obs_t sample_raw();
    obs_t g;
    g.rf_we     = rf_we;
    g.rf_waddr  = rf_waddr;
    g.rf_wdata  = rf_wdata;
    g.im_we     = im_we;
    g.im_addr   = im_addr;
    g.im_wdata  = im_wdata;
    g.cpu_rst_n = cpu_reset_n;
    g.done      = done;
    g.busy      = busy;
    g.berr      = boot_error;
    return g;
  endfunction

  // Address/data are only meaningful while the matching write enable is high.
  function automatic obs_t sample(obs_t e);
    obs_t g = sample_raw();
    if (!e.rf_we) g.rf_waddr = '0;
    if (!e.im_we) begin
      g.im_addr  = '0;
      g.im_wdata = '0;
    end
    return g;
  endfunction

  task automatic test_reset();
    obs_t g;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 g = sample_raw();
    n_cmp++;
    if (g !== obs_t'('0)) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", g, obs_t'('0));
    end
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      g = sample_raw();
      n_cmp++;
      if (g !== obs_t'('0)) begin
        n_err++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, g, obs_t'('0));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_boot();
    obs_t e, g;
    @(negedge clk) rst_n = 1'b1;
    push_seq(LEN + 1, pat_a, pat_b, 1'b0);
    for (int k = 1; k <= LEN + 1; k++) begin
      @(posedge clk); #1;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL boot k=%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_abort();
    obs_t e, g;
    #1 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    push_seq(6, pat_a, pat_b, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL abort_pre k=%0d got=%h exp=%h", k, g, e);
      end
    end
    // Mid FILL_IM: reset must clear everything without waiting for a clock.
    #2 rst_n = 1'b0;
    #1 g = sample_raw();
    n_cmp++;
    if (g !== obs_t'('0)) begin
      n_err++;
      $display("FAIL abort_clear got=%h exp=%h", g, obs_t'('0));
    end
    @(negedge clk) rst_n = 1'b1;
    push_seq(LEN + 1, pat_a, pat_b, 1'b0);
    for (int k = 1; k <= LEN + 1; k++) begin
      @(posedge clk); #1;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL abort_rerun k=%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_restart();
    obs_t e, g;
    pat_a = 32'hDEADBEEF;
    pat_b = 32'h0F0F0F0F;
    start = 1'b1;
    push_seq(LEN + 1, pat_a, pat_b, 1'b0);
    for (int k = 1; k <= LEN + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == N + 3) start = 1'b1;  // sampled during FILL_IM: ignored
      if (k == N + 4) start = 1'b0;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    pat_a = $urandom();
    pat_b = $urandom();
    start = 1'b1;
    push_seq(LEN, pat_a, pat_b, 1'b0);
    push_seq(LEN + 1, pat_a, pat_b, 1'b0);
    for (int k = 1; k <= 2 * LEN + 1; k++) begin
      @(posedge clk); #1;
      if (k == LEN + 3) start = 1'b0;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL back_to_back k=%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

`ifdef BOOT_VERIFY_EN
  task automatic test_verify_error();
    obs_t e, g;
    corrupt = 1'b1;
    start   = 1'b1;
    push_seq(N + 2 * M + 3, pat_a, pat_b, 1'b1);
    for (int k = 1; k <= N + 2 * M + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL verify_err k=%0d got=%h exp=%h", k, g, e);
      end
    end
    corrupt = 1'b0;
    start   = 1'b1;
    push_seq(LEN + 1, pat_a, pat_b, 1'b0);
    for (int k = 1; k <= LEN + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      e = q_exp.pop_front();
      g = sample(e);
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL verify_recover k=%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask
`endif

  task automatic test_defaults();
    int edges = 0;
    int rf_n  = 0;
    int im_n  = 0;
    int bad   = 0;
    int rise  = 0;
    @(negedge clk) rst2_n = 1'b1;
    while (rise == 0 && edges < 10000) begin
      @(posedge clk); #1;
      edges++;
      if (d_rf_we) begin
        if (int'(d_rf_waddr) != rf_n || d_rf_wdata != 32'h0) bad++;
        rf_n++;
      end
      if (d_im_we) begin
        if (int'(d_im_addr) != im_n) bad++;
        im_n++;
      end
      if (d_rf_we && d_im_we) bad++;
      if (d_cpu_reset_n) rise = edges;
    end
    n_cmp++;
    if (rise != DEF_RISE) begin
      n_err++;
      $display("FAIL def_release edge got=%0d exp=%0d", rise, DEF_RISE);
    end
    n_cmp++;
    if (rf_n != 34) begin
      n_err++;
      $display("FAIL def_rf_writes got=%0d exp=%0d", rf_n, 34);
    end
    n_cmp++;
    if (im_n != 4096) begin
      n_err++;
      $display("FAIL def_im_writes got=%0d exp=%0d", im_n, 4096);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL def_order bad_writes got=%0d exp=%0d", bad, 0);
    end
    n_cmp++;
    if ({d_done, d_busy, d_boot_error} !== 3'b100) begin
      n_err++;
      $display("FAIL def_run_flags got=%b exp=%b", {d_done, d_busy, d_boot_error}, 3'b100);
    end
  endtask

  initial begin
    rst2_n  = 1'b1;
    start   = 1'b0;
    corrupt = 1'b0;
    pat_a   = 32'h012A4020;
    pat_b   = 32'h012A4023;
    #1 rst2_n = 1'b0;
    test_reset();
    test_boot();
    test_abort();
    test_restart();
    test_back_to_back();
`ifdef BOOT_VERIFY_EN
    test_verify_error();
`endif
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
